// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES-128 inverse cipher, one round per clock
module aes_inv_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] cypherText,
    output logic         busy,
    output logic         done,
    output logic [127:0] plainText
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, DEC, DONE} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        inv_sbox = INV_SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns built from xtime chains: 9, b, d, e multiples.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        inv_mix_col = '0;
        for (int i = 0; i < 4; i++) begin
            a     = col[31-8*i -: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int i = 0; i < 4; i++)
            inv_mix_col[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    endfunction

    state_t       state, state_n;
    logic [127:0] rk, rk_n, ct, ct_n, st, st_n, pt_n;
    logic [3:0]   rnd, rnd_n;
    logic         busy_n, done_n;

    logic [31:0]  ks_in, ks_sub;
    logic [127:0] fwd_key, rev_key, isr, isb, ark, imc;

    // Shared key-path S-box: forward expansion uses w3, the reverse step uses w3^w2.
    always_comb begin
        ks_in   = (state == KEYEXP) ? rk[31:0] : rk[31:0] ^ rk[63:32];
        ks_sub  = {sbox(ks_in[23:16]), sbox(ks_in[15:8]), sbox(ks_in[7:0]), sbox(ks_in[31:24])}
                ^ {rcon(rnd), 24'h0};
        fwd_key[127:96] = rk[127:96] ^ ks_sub;
        fwd_key[95:64]  = rk[95:64] ^ fwd_key[127:96];
        fwd_key[63:32]  = rk[63:32] ^ fwd_key[95:64];
        fwd_key[31:0]   = rk[31:0] ^ fwd_key[63:32];
        rev_key[127:96] = rk[127:96] ^ ks_sub;
        rev_key[95:64]  = rk[95:64] ^ rk[127:96];
        rev_key[63:32]  = rk[63:32] ^ rk[95:64];
        rev_key[31:0]   = rk[31:0] ^ rk[63:32];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
            assign isb[127-8*(4*c+r) -: 8] = inv_sbox(isr[127-8*(4*c+r) -: 8]);
        end
        assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
    assign ark = isb ^ rk;

    // Next-state and datapath updates; everything holds unless the current state advances it.
    always_comb begin
        state_n = state;
        rk_n    = rk;
        ct_n    = ct;
        st_n    = st;
        rnd_n   = rnd;
        busy_n  = busy;
        done_n  = done;
        pt_n    = plainText;
        case (state)
            IDLE, DONE: if (load) begin
                state_n = KEYEXP;
                rk_n    = key;
                ct_n    = cypherText;
                rnd_n   = 4'd1;
                busy_n  = 1'b1;
                done_n  = 1'b0;
            end
            KEYEXP: begin
                rk_n    = fwd_key;
                rnd_n   = (rnd == 4'(NR)) ? rnd : rnd + 4'd1;
                state_n = (rnd == 4'(NR)) ? INIT : KEYEXP;
            end
            INIT: begin
                st_n    = ct ^ rk;
                rk_n    = rev_key;
                rnd_n   = 4'(NR - 1);
                state_n = DEC;
            end
            DEC: if (rnd == 4'd0) begin
                pt_n    = ark;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = DONE;
            end else begin
                st_n  = imc;
                rk_n  = rev_key;
                rnd_n = rnd - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rk        <= '0;
            ct        <= '0;
            st        <= '0;
            rnd       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            plainText <= '0;
        end else begin
            state     <= state_n;
            rk        <= rk_n;
            ct        <= ct_n;
            st        <= st_n;
            rnd       <= rnd_n;
            busy      <= busy_n;
            done      <= done_n;
            plainText <= pt_n;
        end
    end
endmodule

// File: tb/tb_aes_inv_core.sv
// tb_aes_inv_core: vectors, corner sequences and random encrypt/decrypt round trips
module tb_aes_inv_core;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] cypherText = '0;
    logic         busy, done;
    logic [127:0] plainText;

    int total = 0;
    int bad = 0;
    logic [7:0] sb [256];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [3];

    aes_inv_core #(.NR(10)) dut (
        .clk(clk), .reset(reset), .load(load), .key(key), .cypherText(cypherText),
        .busy(busy), .done(done), .plainText(plainText)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sb[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rd < 10 ? gf_mul(t[4*c+r], 8'h02) ^ gf_mul(t[4*c+(r+1)%4], 8'h03)
                                          ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4]
                                        : t[4*c+r]) ^ w[4*rd+c][31-8*r -: 8];
        end
        for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
        return out;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_one(input logic [127:0] k, input logic [127:0] c,
                           output logic [127:0] p, output int lat, output logic busy_ok);
        key = k;
        cypherText = c;
        load = 1'b1;
        step();
        load = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        cypherText = {$urandom, $urandom, $urandom, $urandom};
        busy_ok = busy;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            step();
            if (done) lat = n;
            else if (!busy) busy_ok = 1'b0;
        end
        if (busy) busy_ok = 1'b0;
        p = plainText;
    endtask

    initial begin
        logic [127:0] got, k, p;
        int lat;
        logic bok;
        logic [7:0] inv, b;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

        key = vecs[0].key;
        cypherText = vecs[0].ct;
        load = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("reset%0d busy", i), busy, 0);
            chk($sformatf("reset%0d done", i), done, 0);
            chk($sformatf("reset%0d pt", i), plainText, 0);
        end
        reset = 1'b0;
        load = 1'b0;
        repeat (3) step();
        chk("post-reset idle busy", busy, 0);
        chk("post-reset idle done", done, 0);

        for (int i = 0; i < 3; i++) begin
            run_one(vecs[i].key, vecs[i].ct, got, lat, bok);
            chk($sformatf("vec%0d latency", i), lat, 21);
            chk($sformatf("vec%0d busy window", i), bok, 1);
            chk($sformatf("vec%0d pt", i), got, vecs[i].pt);
        end

        key = vecs[1].key;
        cypherText = vecs[1].ct;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (10) step();
        chk("B round-10 key", dut.rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (11) step();
        chk("B done at edge 21", done, 1);
        chk("B pt", plainText, vecs[1].pt);

        key = vecs[0].key;
        cypherText = vecs[0].ct;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (6) step();
        key = vecs[1].key;
        cypherText = vecs[1].ct;
        load = 1'b1;
        step();
        load = 1'b0;
        lat = 0;
        for (int n = 8; n <= 40 && lat == 0; n++) begin
            step();
            if (done) lat = n;
        end
        chk("busy-load latency", lat, 21);
        chk("busy-load pt", plainText, vecs[0].pt);

        key = vecs[0].key;
        cypherText = vecs[0].ct;
        load = 1'b1;
        step();
        key = vecs[1].key;
        cypherText = vecs[1].ct;
        repeat (20) step();
        chk("b2b done before edge 21", done, 0);
        step();
        chk("b2b first done", done, 1);
        chk("b2b first pt", plainText, vecs[0].pt);
        step();
        chk("b2b done drop", done, 0);
        chk("b2b busy again", busy, 1);
        chk("b2b pt held", plainText, vecs[0].pt);
        repeat (20) step();
        chk("b2b done before edge 43", done, 0);
        step();
        load = 1'b0;
        chk("b2b second done", done, 1);
        chk("b2b second pt", plainText, vecs[1].pt);

        key = vecs[2].key;
        cypherText = vecs[2].ct;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (14) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid reset busy", busy, 0);
        chk("mid reset done", done, 0);
        chk("mid reset pt", plainText, 0);
        run_one(vecs[0].key, vecs[0].ct, got, lat, bok);
        chk("after reset latency", lat, 21);
        chk("after reset pt", got, vecs[0].pt);

        for (int i = 0; i < 200; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_one(k, aes_enc(k, p), got, lat, bok);
            chk($sformatf("rand%0d latency", i), lat, 21);
            chk($sformatf("rand%0d pt", i), got, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_inv_core.md
Name: aes_inv_core

Overview:
Iterative AES-128 inverse-cipher core (FIPS-197 InvCipher, Nk=4, Nb=4, Nr=10). It is the decryption counterpart of the team's aes_core.
- Takes a 128-bit key and cyphertext and returns the plaintext.
- Derives the round-10 key on chip, then walks the key schedule backwards while applying one inverse round per clock.
- Uses the same byte/word packing as aes_core: [127:120]=S0,0, w[0]=[127:96].

Parameters:
NR, 10, number of rounds (fixed for AES-128; other values unsupported)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
load  input  1  start request; sampled on posedge clk while idle or done
key  input  128  cipher key, captured on accepted load
cypherText  input  128  block to decrypt, captured on accepted load
busy  output  1  high from the cycle after an accepted load until done rises
done  output  1  high while plainText is valid; held until next accepted load or reset
plainText  output  128  decrypted block; valid while done=1

Behaviour:
- Reset (sync, active-high, highest priority over all inputs):
  - state=IDLE, busy=0, done=0, plainText=0, round counter=0, internal key/state registers=0.
- FSM states:
  - IDLE: load=1 -> capture key into rk, cypherText into ct, rnd<=1, go KEYEXP.
  - KEYEXP: each edge rk<=KeyExpand(rk, Rcon[rnd]), rnd++. When rnd=10 at the edge, rk becomes K10; go INIT.
  - INIT: st<=ct^K10; rk<=RevKey(K10, Rcon[10]); rnd<=9; go DEC.
  - DEC, rnd 9..1: st<=InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk)); rk<=RevKey(rk, Rcon[rnd]); rnd--.
  - DEC, rnd=0: plainText<=InvSubBytes(InvShiftRows(st))^rk (rk=K0, no InvMixColumns); done<=1; busy<=0; go DONE.
  - DONE: load=1 -> accepted exactly as in IDLE; done<=0 at the same edge.
- RevKey(Ki, Rcon[i]) gives Ki-1:
  - w'3=w3^w2, w'2=w2^w1, w'1=w1^w0.
  - w'0=w0^SubWord(RotWord(w'3))^{Rcon[i],24'h0}.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 for i=1..10.
- Latency: the accepting edge is edge 0.
  - Edges 1-10: KEYEXP. Edge 11: INIT. Edges 12-20: DEC rounds 9..1. Edge 21: final round.
  - done=1 and plainText valid after edge 21; throughput is one block per 22 cycles.
- busy: 1 after edge 0 through edge 20; 0 after edge 21.
- load while busy: ignored; key/cypherText changes during busy have no effect.
- load held high continuously: accepted in IDLE/DONE only, so back-to-back decrypts run at 22-cycle spacing.
- plainText holds its last value until the next final round or reset (not cleared on a new load).
- S-boxes:
  - Inverse S-box (16 lanes) and forward S-box (4 lanes, key path) are combinational ROMs.
  - Both are initialised from the team's sbox/invsbox hex files.
- InvMixColumns: per column multiply by {0e,0b,0d,09} in GF(2^8), poly 0x11b. Use xtime chains, no multipliers.
- Reset asserted mid-operation: returns to IDLE next edge with all outputs zero. A load in the same cycle as reset is dropped.

Test Plan:
- Reset check: reset=1 for 2 cycles with load=1 -> busy=0, done=0, plainText=0, no operation starts after reset deasserts unless load is still high.
- FIPS-197 C.1 vector: key=000102030405060708090a0b0c0d0e0f, cypherText=69c4e0d86a7b0430d8cdb78070b4c55a, 1-cycle load -> done rises after exactly edge 21 with plainText=00112233445566778899aabbccddeeff; busy high for edges 1-20.
- FIPS-197 B vector: key=2b7e151628aed2a6abf7158809cf4f3c, cypherText=3925841d02dc09fbdc118597196a0b32 -> plainText=3243f6a8885a308d313198a2e0370734. Also probe internal rk=d014f9a8c9ee2589e13f0cc8b6630ca6 after edge 10.
- Load during busy: pulse load with a different key/cypherText at edge 7 -> ignored, result still matches the first vector at edge 21.
- Back-to-back: hold load=1 with the C.1 vector, then the B vector at the next accepting edge -> done drops at edge 21+1 and results appear at edges 21 and 43.
- Reset mid-run: assert reset at edge 15 of a decrypt -> done=0, busy=0, plainText=0 next edge. A fresh load then completes correctly in 21 edges.
- Random cross-check: 200 random key/plaintext pairs encrypted by aes_core, then decrypted by this block -> original plaintext recovered every time.
